fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RISC-V core. Directly upstream of the control decoder.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, issues imem requests, buffers words for decode
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  Imem_Req_o,
  output logic [ADDR_WIDTH-1:0] Imem_Addr_o,
  input  logic                  Imem_Valid_i,
  input  logic [31:0]           Imem_Data_i,
  input  logic                  Redirect_i,
  input  logic [ADDR_WIDTH-1:0] Redirect_PC_i,
  output logic                  Instr_Valid_o,
  output logic [31:0]           Instr_o,
  output logic [ADDR_WIDTH-1:0] PC_o,
  input  logic                  Decode_Ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, req_pc;
  logic [31:0]           instr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           last_instr;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic                  busy, push, pop, issue;
  logic [CW:0]           occupancy;

  assign Instr_Valid_o = (count != '0);
  assign Instr_o       = Instr_Valid_o ? instr_mem[rd_ptr] : last_instr;
  assign PC_o          = Instr_Valid_o ? pc_mem[rd_ptr]    : last_pc;
  assign Imem_Addr_o   = fetch_pc;
  assign Imem_Req_o    = issue;

  always_comb begin
    busy      = (state != IDLE);
    pop       = Instr_Valid_o && Decode_Ready_i && !Redirect_i;
    push      = (state == WAIT) && Imem_Valid_i && !Redirect_i && !reset;
    // a head popped this cycle frees its slot, so a 1-cycle memory streams without bubbles
    occupancy = {1'b0, count} + {{CW{1'b0}}, busy} - {{CW{1'b0}}, pop};
    issue     = !reset && !Redirect_i && (occupancy < (CW+1)'(FIFO_DEPTH))
                && ((state == IDLE) || ((state == WAIT) && Imem_Valid_i));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) state_next = WAIT;
      end
      WAIT: begin
        if (Redirect_i)        state_next = Imem_Valid_i ? IDLE : WAIT_DISCARD;
        else if (Imem_Valid_i) state_next = issue ? WAIT : IDLE;
      end
      WAIT_DISCARD: begin
        if (Imem_Valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else begin
      state <= state_next;
      if (Instr_Valid_o) begin
        last_instr <= Instr_o;
        last_pc    <= PC_o;
      end
      if (Redirect_i) begin
        fetch_pc <= {Redirect_PC_i[ADDR_WIDTH-1:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // the word returning now belongs to the request captured at the previous issue
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= Imem_Data_i;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a random-latency memory model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic        Imem_Valid_i = 1'b0;
  logic [31:0] Imem_Data_i = '0;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_PC_i = '0;
  logic        Instr_Valid_o;
  logic [31:0] Instr_o;
  logic [31:0] PC_o;
  logic        Decode_Ready_i = 1'b0;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .Imem_Req_o(Imem_Req_o), .Imem_Addr_o(Imem_Addr_o),
    .Imem_Valid_i(Imem_Valid_i), .Imem_Data_i(Imem_Data_i),
    .Redirect_i(Redirect_i), .Redirect_PC_i(Redirect_PC_i),
    .Instr_Valid_o(Instr_Valid_o), .Instr_o(Instr_o), .PC_o(PC_o),
    .Decode_Ready_i(Decode_Ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          req_count = 0;
  int          pop_count = 0;
  logic [31:0] req_exp = RESET_PC;
  logic [31:0] gen_pc = RESET_PC;
  exp_t        exp_q[$];
  pend_t       pend_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory: one response per request after a random latency; responses to requests
  // that predate a reset are still delivered and must be ignored by the DUT
  always begin
    @(posedge clk);
    #1;
    cyc++;
    Imem_Valid_i = 1'b0;
    Imem_Data_i  = $urandom;
    for (int i = 0; i < pend_q.size(); i++) begin
      if (pend_q[i].due <= cyc) begin
        Imem_Valid_i = 1'b1;
        Imem_Data_i  = mem_word(pend_q[i].addr);
        pend_q.delete(i);
        break;
      end
    end
    @(negedge clk);
    if (reset) begin
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
    end
    if (Imem_Req_o) begin
      int live;
      pend_t p;
      live = 0;
      foreach (pend_q[i]) if (!pend_q[i].stale) live++;
      check("outstanding", 32'(live), 32'd0);
      check("req_addr", Imem_Addr_o, req_exp);
      req_exp = req_exp + 32'd4;
      req_count++;
      p.addr  = Imem_Addr_o;
      p.due   = cyc + int'($urandom_range(lat_max, lat_min));
      p.stale = 1'b0;
      pend_q.push_back(p);
    end
  end

  // monitor: every accepted instruction must be the next one of the expected stream
  always @(negedge clk) begin
    if (!reset && Instr_Valid_o && Decode_Ready_i && !Redirect_i) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got pc 0x%08h expected no instruction", PC_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc", PC_o, e.pc);
        check("instr", Instr_o, e.instr);
      end
    end
  end

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_t e;
      e.pc    = gen_pc;
      e.instr = mem_word(gen_pc);
      exp_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    Redirect_i = 1'b0;
    top_up();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    Redirect_i    = 1'b1;
    Redirect_PC_i = target;
    exp_q.delete();
    gen_pc  = {target[31:2], 2'b00};
    req_exp = {target[31:2], 2'b00};
    top_up();
  endtask

  task automatic start_reset();
    reset = 1'b1;
    exp_q.delete();
    gen_pc  = RESET_PC;
    req_exp = RESET_PC;
  endtask

  task automatic apply_reset(input int n);
    start_reset();
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int          rc0;
    bit          found;
    logic [31:0] t;

    // reset values and streaming with a 1-cycle memory
    Decode_Ready_i = 1'b1;
    start_reset();
    step();
    step();
    @(negedge clk);
    check("rst_req", 32'(Imem_Req_o), 32'd0);
    check("rst_valid", 32'(Instr_Valid_o), 32'd0);
    check("rst_instr", Instr_o, 32'd0);
    check("rst_pc", PC_o, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      @(negedge clk);
      check("stream_req", 32'(Imem_Req_o), 32'd1);
      check("stream_addr", Imem_Addr_o, RESET_PC + 32'(4 * k));
      check("stream_valid", 32'(Instr_Valid_o), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) check("stream_pc_lag", PC_o, RESET_PC + 32'(4 * (k - 2)));
    end

    // decode stalled from reset: exactly two words buffered, then drained in order
    step();
    Decode_Ready_i = 1'b0;
    apply_reset(4);
    rc0 = req_count;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (k >= 2) check("stall_no_req", 32'(Imem_Req_o), 32'd0);
    end
    check("stall_buffered", 32'(req_count - rc0), 32'd2);
    check("stall_valid", 32'(Instr_Valid_o), 32'd1);
    step();
    Decode_Ready_i = 1'b1;
    @(negedge clk);
    check("stall_first_pc", PC_o, RESET_PC);
    check("stall_first_instr", Instr_o, mem_word(RESET_PC));

    // redirect while a 3-cycle fetch is in flight
    step();
    lat_min = 3;
    lat_max = 3;
    apply_reset(4);
    @(negedge clk);
    check("slow_req", 32'(Imem_Req_o), 32'd1);
    step();
    do_redirect(32'h0040_0100);
    @(negedge clk);
    check("discard_no_req0", 32'(Imem_Req_o), 32'd0);
    step();
    @(negedge clk);
    check("discard_no_req1", 32'(Imem_Req_o), 32'd0);
    step();
    @(negedge clk);
    check("discard_no_req2", 32'(Imem_Req_o), 32'd0);
    step();
    @(negedge clk);
    check("discard_req", 32'(Imem_Req_o), 32'd1);
    check("discard_addr", Imem_Addr_o, 32'h0040_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      @(negedge clk);
      if (Instr_Valid_o) begin
        found = 1'b1;
        check("discard_first_pc", PC_o, 32'h0040_0100);
      end
    end
    if (!found) check("discard_first_timeout", 32'd0, 32'd1);

    // redirect coincident with a response while the buffer is full
    step();
    lat_min = 1;
    lat_max = 1;
    Decode_Ready_i = 1'b0;
    apply_reset(4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (Imem_Valid_i && Instr_Valid_o) begin
        found = 1'b1;
        do_redirect(32'h0040_0200);
      end else begin
        step();
      end
    end
    if (!found) check("coincident_timeout", 32'd0, 32'd1);
    step();
    Decode_Ready_i = 1'b1;
    @(negedge clk);
    check("coincident_empty", 32'(Instr_Valid_o), 32'd0);
    check("coincident_req", 32'(Imem_Req_o), 32'd1);
    check("coincident_addr", Imem_Addr_o, 32'h0040_0200);

    // unaligned redirect target and address wrap
    step();
    do_redirect(32'h0040_0107);
    step();
    @(negedge clk);
    check("unaligned_addr", Imem_Addr_o, 32'h0040_0104);
    step();
    do_redirect(32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("wrap_addr0", Imem_Addr_o, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("wrap_addr1", Imem_Addr_o, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("wrap_req2", 32'(Imem_Req_o), 32'd1);
    check("wrap_addr2", Imem_Addr_o, 32'h0000_0000);

    // reset while waiting, with the response arriving the cycle after
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      @(negedge clk);
      found = Imem_Req_o;
    end
    if (!found) check("midreset_timeout", 32'd0, 32'd1);
    step();
    start_reset();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_req", 32'(Imem_Req_o), 32'd1);
    check("midreset_addr", Imem_Addr_o, RESET_PC);

    // random traffic: decode back-pressure, memory latency and redirects
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      Decode_Ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else t = $urandom;
        do_redirect(t);
      end
    end
    Decode_Ready_i = 1'b1;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
